// File: rtl/snake_pkg.sv
// snake_pkg: shared types, grid defaults and direction helper for the snake game
// Exports game_mode, direction_t, state_t, GRID_W_DEF, GRID_H_DEF, opposite().
package snake_pkg;
  typedef enum logic [1:0] {MENU, GAME, OVER} game_mode;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} direction_t;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;
  function automatic direction_t opposite(input direction_t d);
    return d == UP ? DOWN : d == DOWN ? UP : d == LEFT ? RIGHT : LEFT;
  endfunction
endpackage

// File: rtl/tick_edge_det.sv
// tick_edge_det: one-cycle tick on every toggle of a same-domain square wave
// Ports: clk, rst (async active-low), din (divider wave), tick (din changed since last edge).
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick
);
  logic din_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) din_q <= 1'b0;
    else din_q <= din;
  assign tick = din ^ din_q;
endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: snake head stepping FSM with direction filtering and grid wrap
// Ports: clk, rst (async active-low), mode, clk_divided (game tick wave), hold (pause),
//        dir_req/dir_req_valid (steering), head_x/head_y (head cell), dir (committed), step (move pulse).
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int START_X = 16,
  parameter int START_Y = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  game_mode   mode,
  input  logic       clk_divided,
  input  logic       hold,
  input  direction_t dir_req,
  input  logic       dir_req_valid,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output direction_t dir,
  output logic       step
);
  localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
  localparam logic [5:0] Y_MAX = 6'(GRID_H - 1);
  localparam logic [5:0] X0 = 6'(START_X);
  localparam logic [5:0] Y0 = 6'(START_Y);
  state_t state;
  direction_t pending;
  logic tick, accept;
  logic [5:0] nx, ny;
  tick_edge_det u_tick (.clk(clk), .rst(rst), .din(clk_divided), .tick(tick));
  always_comb begin
    nx = pending == RIGHT ? (head_x == X_MAX ? 6'd0 : head_x + 6'd1)
       : pending == LEFT  ? (head_x == 6'd0 ? X_MAX : head_x - 6'd1) : head_x;
    ny = pending == DOWN  ? (head_y == Y_MAX ? 6'd0 : head_y + 6'd1)
       : pending == UP    ? (head_y == 6'd0 ? Y_MAX : head_y - 6'd1) : head_y;
  end
  // reversal is judged against the committed direction, not the pending one
  assign accept = dir_req_valid && dir_req != opposite(dir);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      head_x  <= X0;
      head_y  <= Y0;
      dir     <= RIGHT;
      pending <= RIGHT;
      step    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (mode != GAME) state <= IDLE;
      else if (state == IDLE) begin
        state   <= RUN;
        head_x  <= X0;
        head_y  <= Y0;
        dir     <= RIGHT;
        pending <= RIGHT;
      end else begin
        // a same-edge tick consumes the old pending; the new request waits for the next tick
        if (accept) pending <= dir_req;
        state <= hold ? PAUSE : RUN;
        if (state == RUN && !hold && tick) begin
          dir    <= pending;
          head_x <= nx;
          head_y <= ny;
          step   <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: directed vector table plus wrap, mode-exit and async-reset sequences
module tb_snake_step_ctrl;
  import snake_pkg::*;
  logic clk = 1'b0, rst = 1'b0, clk_divided = 1'b0, hold = 1'b0, dir_req_valid = 1'b0;
  game_mode mode = MENU;
  direction_t dir_req = UP;
  logic [5:0] hx, hy, w1x, w1y, w2x, w2y;
  direction_t d, w1d, w2d;
  logic st, w1st, w2st;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic hold;
    logic valid;
    direction_t req;
    logic tog;
    int x;
    int y;
    direction_t d;
    logic st;
  } vec_t;
  vec_t v[19];
  snake_step_ctrl u_dut (.clk(clk), .rst(rst), .mode(mode), .clk_divided(clk_divided), .hold(hold),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid), .head_x(hx), .head_y(hy), .dir(d), .step(st));
  snake_step_ctrl #(.START_X(31), .START_Y(5)) u_w1 (.clk(clk), .rst(rst), .mode(mode),
    .clk_divided(clk_divided), .hold(hold), .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .head_x(w1x), .head_y(w1y), .dir(w1d), .step(w1st));
  snake_step_ctrl #(.START_X(3), .START_Y(0)) u_w2 (.clk(clk), .rst(rst), .mode(mode),
    .clk_divided(clk_divided), .hold(hold), .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .head_x(w2x), .head_y(w2y), .dir(w2d), .step(w2st));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic chk_main(input string n, input int x, input int y, input direction_t e_d, input logic e_st);
    chk({n, " x"}, int'(hx), x);
    chk({n, " y"}, int'(hy), y);
    chk({n, " dir"}, int'(d), int'(e_d));
    chk({n, " step"}, int'(st), int'(e_st));
  endtask
  task automatic req(input direction_t r);
    dir_req = r;
    dir_req_valid = 1'b1;
    cyc();
    dir_req_valid = 1'b0;
  endtask
  task automatic tog();
    clk_divided = ~clk_divided;
    cyc();
  endtask
  initial begin
    v[0]  = '{1'b0, 1'b0, UP,    1'b1, 17, 12, RIGHT, 1'b1};
    v[1]  = '{1'b0, 1'b0, UP,    1'b0, 17, 12, RIGHT, 1'b0};
    v[2]  = '{1'b0, 1'b1, LEFT,  1'b0, 17, 12, RIGHT, 1'b0};
    v[3]  = '{1'b0, 1'b0, UP,    1'b1, 18, 12, RIGHT, 1'b1};
    v[4]  = '{1'b0, 1'b1, UP,    1'b0, 18, 12, RIGHT, 1'b0};
    v[5]  = '{1'b0, 1'b1, DOWN,  1'b0, 18, 12, RIGHT, 1'b0};
    v[6]  = '{1'b0, 1'b0, UP,    1'b1, 18, 13, DOWN,  1'b1};
    v[7]  = '{1'b0, 1'b1, RIGHT, 1'b0, 18, 13, DOWN,  1'b0};
    v[8]  = '{1'b0, 1'b0, UP,    1'b1, 19, 13, RIGHT, 1'b1};
    v[9]  = '{1'b0, 1'b1, UP,    1'b1, 20, 13, RIGHT, 1'b1};
    v[10] = '{1'b0, 1'b0, UP,    1'b1, 20, 12, UP,    1'b1};
    v[11] = '{1'b1, 1'b0, UP,    1'b0, 20, 12, UP,    1'b0};
    v[12] = '{1'b1, 1'b0, UP,    1'b1, 20, 12, UP,    1'b0};
    v[13] = '{1'b1, 1'b0, UP,    1'b1, 20, 12, UP,    1'b0};
    v[14] = '{1'b1, 1'b0, UP,    1'b1, 20, 12, UP,    1'b0};
    v[15] = '{1'b0, 1'b0, UP,    1'b0, 20, 12, UP,    1'b0};
    v[16] = '{1'b0, 1'b0, UP,    1'b1, 20, 11, UP,    1'b1};
    v[17] = '{1'b0, 1'b0, LEFT,  1'b0, 20, 11, UP,    1'b0};
    v[18] = '{1'b0, 1'b0, UP,    1'b1, 20, 10, UP,    1'b1};
    repeat (2) cyc();
    chk_main("reset", 16, 12, RIGHT, 1'b0);
    rst = 1'b1;
    mode = GAME;
    cyc();
    chk_main("enter", 16, 12, RIGHT, 1'b0);
    for (int i = 0; i < 19; i++) begin
      hold = v[i].hold;
      dir_req = v[i].req;
      dir_req_valid = v[i].valid;
      if (v[i].tog) clk_divided = ~clk_divided;
      cyc();
      chk_main($sformatf("vec%0d", i), v[i].x, v[i].y, v[i].d, v[i].st);
    end
    hold = 1'b0;
    dir_req_valid = 1'b0;
    mode = MENU;
    tog();
    chk_main("exit drops tick", 20, 10, UP, 1'b0);
    mode = GAME;
    cyc();
    chk_main("reenter", 16, 12, RIGHT, 1'b0);
    cyc();
    chk("reenter idle step", int'(st), 0);
    tog();
    chk_main("after reenter tick", 17, 12, RIGHT, 1'b1);
    chk("w1 right wrap x", int'(w1x), 0);
    chk("w1 right wrap y", int'(w1y), 5);
    req(UP);
    tog();
    chk("w1 up x", int'(w1x), 0);
    chk("w1 up y", int'(w1y), 4);
    req(LEFT);
    tog();
    chk("w1 left wrap x", int'(w1x), 31);
    chk("w1 left wrap y", int'(w1y), 4);
    chk("w1 left dir", int'(w1d), int'(LEFT));
    mode = MENU;
    cyc();
    mode = GAME;
    cyc();
    req(UP);
    tog();
    chk("w2 up wrap x", int'(w2x), 3);
    chk("w2 up wrap y", int'(w2y), 23);
    chk("w2 up step", int'(w2st), 1);
    req(RIGHT);
    tog();
    chk("w2 right x", int'(w2x), 4);
    req(DOWN);
    tog();
    chk("w2 down wrap y", int'(w2y), 0);
    chk("w2 down dir", int'(w2d), int'(DOWN));
    chk_main("main before rst", 17, 12, DOWN, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_main("async rst", 16, 12, RIGHT, 1'b0);
    chk("async rst w2 y", int'(w2y), 0);
    chk("async rst w2 x", int'(w2x), 3);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 32, meaning grid columns (x range 0..GRID_W-1).
REQ-002 SHALL have parameter GRID_H, default 24, meaning grid rows (y range 0..GRID_H-1).
REQ-003 SHALL have parameters START_X, default 16, and START_Y, default 12, meaning head position loaded on game start.
REQ-004 SHALL have ports: clk  in  1  system clock; all logic on posedge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: mode  in  game_mode  current game mode; only GAME runs the block.
REQ-007 SHALL have ports: clk_divided  in  1  game-tick square wave from the divider, same clk domain.
REQ-008 SHALL have ports: hold  in  1  pause request; freezes stepping while high.
REQ-009 SHALL have ports: dir_req  in  direction_t  requested direction; dir_req_valid  in  1  request qualifier.
REQ-010 SHALL have ports: head_x  out  6  head column; head_y  out  6  head row.
REQ-011 SHALL have ports: dir  out  direction_t  committed direction; step  out  1  one-cycle pulse per completed move.

Function
REQ-012 SHALL register clk_divided into div_q every cycle in every state; tick = clk_divided XOR div_q (each divider toggle is one tick).
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-014 IDLE -> RUN when mode == GAME; on that edge load head = (START_X, START_Y), dir = RIGHT, pending = RIGHT, step = 0.
REQ-015 RUN -> PAUSE when hold == 1; PAUSE -> RUN when hold == 0; ticks in PAUSE are discarded, not queued.
REQ-016 Any state -> IDLE when mode != GAME (priority over hold); IDLE holds head/dir outputs unchanged, step = 0.
REQ-017 In RUN with tick == 1 and hold == 0: dir <= pending; head moves one cell in pending direction; step <= 1 on the same edge.
REQ-018 Latency: step and new head visible in the cycle immediately after the cycle in which clk_divided toggled; step high exactly one cycle.
REQ-019 Direction request accepted into pending in RUN or PAUSE only when dir_req_valid == 1 and dir_req is not the reverse of committed dir; reversals silently dropped.
REQ-020 Multiple accepted requests between ticks: last one wins.
REQ-021 Request and tick on same edge: tick uses old pending; new request is stored in pending for the next tick.
REQ-022 Wrap-around: RIGHT at x=GRID_W-1 -> x=0; LEFT at x=0 -> GRID_W-1; DOWN at y=GRID_H-1 -> y=0; UP at y=0 -> GRID_H-1.
REQ-023 Arithmetic in 6-bit unsigned with explicit wrap compare; no modulo operator; GRID_W, GRID_H <= 64.
REQ-024 Mode leaving GAME mid-run drops any pending tick on that edge; re-entry reloads start values per REQ-014.

Reset
REQ-025 rst low asynchronously forces: state IDLE, head = (START_X, START_Y), dir = RIGHT, pending = RIGHT, step = 0, div_q = 0.
REQ-026 Deassertion is synchronous to clk by the system reset bridge; the first tick cannot occur before the second edge after release.

Structure
REQ-027 direction_t (UP, DOWN, LEFT, RIGHT, 2 bits) and the opposite-direction function SHALL live in snake_pkg beside game_mode.
REQ-028 GRID_W/GRID_H defaults SHALL be snake_pkg constants reused by the parameter defaults.
REQ-029 Tick edge detector MAY be a sub-module named tick_edge_det; the rest stays flat.

Verification
REQ-030 Reset, mode=GAME, toggle clk_divided once -> next cycle step=1 for one cycle, head=(17,12), dir=RIGHT.
REQ-031 From (31,5) dir RIGHT, one tick -> head=(0,5); from (3,0) dir UP, one tick -> head=(3,23).
REQ-032 dir RIGHT, request LEFT then tick -> request dropped, head x+1; request UP then DOWN in one tick window, dir RIGHT -> DOWN applied.
REQ-033 Request UP on the same edge as a tick while pending=RIGHT -> that tick moves right, next tick moves up.
REQ-034 hold=1 across 3 toggles -> no step, head unchanged; hold=0 then one toggle -> exactly one step.
REQ-035 mode set to non-GAME mid-run then back to GAME -> head=(16,12), dir=RIGHT, no step until next toggle; rst low mid-run -> outputs at REQ-025 values immediately, without waiting for a clk edge.
